// File: rtl/fft_mem_sequencer_pkg.sv
// fft_mem_sequencer_pkg: shared sample type, FSM state encoding and default transform size
package fft_mem_sequencer_pkg;
  localparam int DW = 16;
  typedef logic [2*DW-1:0] complex_t;
  localparam int A_LEN_DEF = 5;
  localparam int N = 2**A_LEN_DEF;
  localparam int HALF = N/2;
  typedef enum logic [3:0] {
    st_idle, st_read, st_wait, st_wr_a, st_wr_b, st_done,
    st_br_chk, st_br_rd, st_br_wa, st_br_wb
  } state_t;
endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps stage s and butterfly k to the in-place operand pair and twiddle index
module fft_addr_gen #(
  parameter int A_LEN = 5,
  parameter int SW = $clog2(A_LEN)
) (
  input  logic [SW-1:0]    s,
  input  logic [A_LEN-2:0] k,
  output logic [A_LEN-1:0] a,
  output logic [A_LEN-1:0] b,
  output logic [A_LEN-2:0] tw
);
  logic [A_LEN-1:0] kx, span, lo;
  assign kx = {1'b0, k};
  assign span = A_LEN'(1) << s;
  assign lo = kx & (span - A_LEN'(1));
  assign a = (((kx >> s) << s) << 1) | lo;
  assign b = a | span;
  assign tw = (A_LEN-1)'(lo << (SW'(A_LEN - 1) - s));
endmodule

// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer: in-place radix-2 DIT FFT memory sequencer; FFT_SEQ_BITREV_EN adds a bit-reversal pre-pass
module fft_mem_sequencer
  import fft_mem_sequencer_pkg::*;
#(
  parameter int A_LEN = A_LEN_DEF,
  parameter int DEPTH = 2**A_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [A_LEN-1:0] raddr1,
  output logic [A_LEN-1:0] raddr2,
  input  complex_t         rdata1,
  input  complex_t         rdata2,
  output complex_t         op_a,
  output complex_t         op_b,
  output logic [A_LEN-2:0] tw_idx,
  output logic             op_valid,
  input  complex_t         res_a,
  input  complex_t         res_b,
  input  logic             res_valid,
  output logic [A_LEN-1:0] waddr,
  output complex_t         wdata,
  output logic             wr_en,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(A_LEN);
  if (DEPTH != 2**A_LEN || A_LEN < 2) begin : g_bad_cfg
    $error("fft_mem_sequencer: DEPTH must equal 2**A_LEN and A_LEN must be >= 2");
  end
  state_t state, nxt;
  logic [SW-1:0] s;
  logic [A_LEN-2:0] k, tw;
  logic [A_LEN-1:0] a, b, i, ri;
  complex_t ra, rb;
  logic last_k, last_s, bf_ph, br_ph;
  fft_addr_gen #(.A_LEN(A_LEN), .SW(SW)) u_ag (.s(s), .k(k), .a(a), .b(b), .tw(tw));
  assign last_k = &k;
  assign last_s = s == SW'(A_LEN - 1);
  assign bf_ph = state inside {st_read, st_wait, st_wr_a, st_wr_b};
  assign br_ph = state inside {st_br_rd, st_br_wa, st_br_wb};
`ifdef FFT_SEQ_BITREV_EN
  logic swap, last_i;
  for (genvar g = 0; g < A_LEN; g++) begin : g_rev
    assign ri[g] = i[A_LEN-1-g];
  end
  assign swap = i < ri;
  assign last_i = &i;
  // swap index advances on every skipped index and after each completed swap
  always_ff @(posedge clk)
    if (rst) i <= '0;
    else if ((state == st_br_chk && !swap) || state == st_br_wb) i <= i + A_LEN'(1);
`else
  assign i = '0;
  assign ri = '0;
`endif
  // state, stage/butterfly counters, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_idle;
      s <= '0;
      k <= '0;
      op_a <= '0;
      op_b <= '0;
      op_valid <= 1'b0;
      ra <= '0;
      rb <= '0;
    end else begin
      state <= nxt;
      op_valid <= state == st_read;
      if (state == st_read) begin
        op_a <= rdata1;
        op_b <= rdata2;
      end
      if (state == st_wait && res_valid) begin
        ra <= res_a;
        rb <= res_b;
      end
`ifdef FFT_SEQ_BITREV_EN
      if (state == st_br_rd) begin
        ra <= rdata1;
        rb <= rdata2;
      end
`endif
      if (state == st_wr_b) begin
        k <= k + (A_LEN-1)'(1);
        if (last_k) s <= last_s ? '0 : s + SW'(1);
      end
    end
  end
  // next state: optional swap pass, then READ/WAIT/WR_A/WR_B per butterfly until the last stage
  always_comb begin
    nxt = state;
    case (state)
`ifdef FFT_SEQ_BITREV_EN
      st_idle:   nxt = start ? st_br_chk : st_idle;
      st_br_chk: nxt = swap ? st_br_rd : (last_i ? st_read : st_br_chk);
      st_br_rd:  nxt = st_br_wa;
      st_br_wa:  nxt = st_br_wb;
      st_br_wb:  nxt = last_i ? st_read : st_br_chk;
`else
      st_idle:   nxt = start ? st_read : st_idle;
`endif
      st_read:   nxt = st_wait;
      st_wait:   nxt = res_valid ? st_wr_a : st_wait;
      st_wr_a:   nxt = st_wr_b;
      st_wr_b:   nxt = (last_k && last_s) ? st_done : st_read;
      default:   nxt = st_idle;
    endcase
  end
  assign raddr1 = bf_ph ? a : br_ph ? i : '0;
  assign raddr2 = bf_ph ? b : br_ph ? ri : '0;
  assign tw_idx = bf_ph ? tw : '0;
  assign wr_en = state inside {st_wr_a, st_wr_b, st_br_wa, st_br_wb};
  assign waddr = state == st_wr_a ? a : state == st_wr_b ? b :
                 state == st_br_wa ? i : state == st_br_wb ? ri : '0;
  assign wdata = state inside {st_wr_a, st_br_wb} ? ra : state inside {st_wr_b, st_br_wa} ? rb : '0;
  assign busy = !(state inside {st_idle, st_done});
  assign done = state == st_done;
endmodule

// File: tb/tb_fft_mem_sequencer.sv
// tb_fft_mem_sequencer: directed self-checking bench with sample memory and reference butterfly model
module tb_fft_mem_sequencer;
  import fft_mem_sequencer_pkg::*;
  localparam int AL = 5, NP = 32, NB = 80;
`ifdef FFT_SEQ_BITREV_EN
  localparam int BRC = 68, BRW = 24, R1 = 16, R3 = 24;
`else
  localparam int BRC = 0, BRW = 0, R1 = 1, R3 = 3;
`endif
  localparam complex_t ONE = {16'd16384, 16'd0};
  logic clk = 0, rst = 1, start = 0;
  logic op_valid, res_valid, wr_en, busy, done;
  logic [AL-1:0] raddr1, raddr2, waddr;
  logic [AL-2:0] tw_idx;
  complex_t rdata1, rdata2, op_a, op_b, res_a, res_b, wdata, ea, eb;
  complex_t mem [NP];
  logic [1:0] init_req = 0;
  logic [118:0] outs;
  logic [77:0] h;
  logic found;
  int dly = 0, wcnt = 0, nb = 0, nw = 0, nd = 0, bb = 0, bw = 0, bd = 0, w0 = 0;
  int errs = 0, chks = 0;
  logic [AL-1:0] tr_a [NB], tr_b [NB], tr_w [2*NB+BRW];
  logic [AL-2:0] tr_t [NB];
  typedef struct { int s; int k; logic [4:0] a; logic [4:0] b; logic [3:0] t; } vec_t;
  vec_t tab [10];

  fft_mem_sequencer #(.A_LEN(AL), .DEPTH(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .op_a(op_a), .op_b(op_b), .tw_idx(tw_idx),
    .op_valid(op_valid), .res_a(res_a), .res_b(res_b), .res_valid(res_valid),
    .waddr(waddr), .wdata(wdata), .wr_en(wr_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bf(input complex_t x, input complex_t y, input logic [AL-2:0] t);
    real c, sn, yr, yi, pr, pim, xr, xi;
    c = $cos(6.283185307179586 * t / NP);
    sn = -$sin(6.283185307179586 * t / NP);
    xr = $itor($signed(x[31:16]));
    xi = $itor($signed(x[15:0]));
    yr = $itor($signed(y[31:16]));
    yi = $itor($signed(y[15:0]));
    pr = c * yr - sn * yi;
    pim = c * yi + sn * yr;
    return {16'($rtoi(xr + pr)), 16'($rtoi(xi + pim)), 16'($rtoi(xr - pr)), 16'($rtoi(xi - pim))};
  endfunction

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];
  assign {res_a, res_b} = bf(op_a, op_b, tw_idx);
  assign res_valid = dly == 0 ? op_valid : wcnt == dly;
  assign outs = {raddr1, raddr2, op_a, op_b, tw_idx, op_valid, waddr, wdata, wr_en, busy, done};

  always @(posedge clk) wcnt <= op_valid ? 1 : res_valid ? 0 : wcnt != 0 ? wcnt + 1 : 0;

  always @(posedge clk)
    if (init_req == 2'd1) for (int j = 0; j < NP; j++) mem[j] <= j == 0 ? ONE : '0;
    else if (init_req == 2'd2) for (int j = 0; j < NP; j++) mem[j] <= {16'(j), 16'h0};
    else if (wr_en) mem[waddr] <= wdata;

  always @(negedge clk) begin
    if (op_valid) begin
      if (nb - bb < NB) begin
        tr_a[nb-bb] = raddr1;
        tr_b[nb-bb] = raddr2;
        tr_t[nb-bb] = tw_idx;
      end
      nb++;
    end
    if (wr_en) begin
      if (nw - bw < 2*NB+BRW) tr_w[nw-bw] = waddr;
      nw++;
    end
    if (done) nd++;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic init(input logic [1:0] v);
    @(negedge clk) init_req = v;
    @(posedge clk);
    #1 init_req = 0;
    bb = nb;
    bw = nw;
    bd = nd;
  endtask

  task automatic run_start();
    @(negedge clk) start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("busy after start", busy, 1);
  endtask

  task automatic wait_done(input int exp_n, input string nm);
    int n = 0;
    while (n < 2000 && !done) begin
      @(posedge clk);
      #1 n++;
    end
    if (exp_n >= 0) chk(nm, n, exp_n);
    else chk(nm, done, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{0, 0, 5'd0, 5'd1, 4'd0};
    tab[1] = '{1, 1, 5'd1, 5'd3, 4'd8};
    tab[2] = '{4, 15, 5'd15, 5'd31, 4'd15};
    tab[3] = '{0, 5, 5'd10, 5'd11, 4'd0};
    tab[4] = '{2, 5, 5'd9, 5'd13, 4'd4};
    tab[5] = '{3, 6, 5'd6, 5'd14, 4'd12};
    tab[6] = '{4, 0, 5'd0, 5'd16, 4'd0};
    tab[7] = '{1, 6, 5'd12, 5'd14, 4'd0};
    tab[8] = '{3, 13, 5'd21, 5'd29, 4'd10};
    tab[9] = '{2, 7, 5'd11, 5'd15, 4'd12};
    repeat (3) @(posedge clk);
    #1 chk("reset outputs", outs, 0);
    rst = 0;

    init(1);
    run_start();
    fork
      begin
        repeat (40) @(negedge clk);
        start = 1;
        @(negedge clk) start = 0;
      end
    join_none
    wait_done(320 + BRC, "impulse done latency");
    @(posedge clk);
    #1 chk("done single cycle", {done, busy}, 0);
    chk("write pulses", nw - bw, 2*NB + BRW);
    chk("op_valid pulses", nb - bb, NB);
    chk("done pulses", nd - bd, 1);
    for (int v = 0; v < 10; v++) begin
      int j;
      j = tab[v].s * 16 + tab[v].k;
      chk($sformatf("read trace s%0d k%0d", tab[v].s, tab[v].k), {tr_a[j], tr_b[j], tr_t[j]},
          {tab[v].a, tab[v].b, tab[v].t});
      chk($sformatf("write trace s%0d k%0d", tab[v].s, tab[v].k), {tr_w[BRW+2*j], tr_w[BRW+2*j+1]},
          {tab[v].a, tab[v].b});
    end
    for (int j = 0; j < NP; j++) chk($sformatf("impulse bin %0d", j), mem[j], ONE);

    dly = 3;
    init(2);
    run_start();
    found = 0;
    for (int n = 0; n < 1000 && !found; n++) @(negedge clk) found = op_valid;
    chk("first op_valid seen", found, 1);
    chk("first pair", {raddr1, raddr2}, {5'd0, 5'd1});
    chk("pre-stage mem0", mem[0], 0);
    chk("pre-stage mem1", mem[1], {16'(R1), 16'h0});
    chk("pre-stage mem3", mem[3], {16'(R3), 16'h0});
    found = 0;
    for (int n = 0; n < 2000 && !found; n++) @(negedge clk) found = op_valid && raddr1 == 5'd9 && raddr2 == 5'd13;
    chk("s2 k5 reached", found, 1);
    chk("s2 k5 tw", tw_idx, 4);
    chk("s2 k5 op_a", op_a, mem[9]);
    chk("s2 k5 op_b", op_b, mem[13]);
    h = {raddr1, raddr2, tw_idx, op_a, op_b};
    {ea, eb} = bf(op_a, op_b, tw_idx);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("wait hold %0d", c), {raddr1, raddr2, tw_idx, op_a, op_b}, h);
      chk($sformatf("wait no write %0d", c), {wr_en, op_valid}, 0);
    end
    chk("res_valid after delay", res_valid, 1);
    @(negedge clk) chk("wr_a", {wr_en, waddr, wdata}, {1'b1, 5'd9, ea});
    @(negedge clk) chk("wr_b", {wr_en, waddr, wdata}, {1'b1, 5'd13, eb});
    wait_done(-1, "delayed run done");
    @(posedge clk);
    #1 chk("delayed run writes", nw - bw, 2*NB + BRW);

    dly = 0;
    init(1);
    run_start();
    for (int n = 0; n < 2000 && nb - bb < 34; n++) begin
      @(posedge clk);
      #1;
    end
    chk("reached stage 2", nb - bb >= 34, 1);
    @(negedge clk);
    rst = 1;
    start = 1;
    @(posedge clk);
    #1 chk("abort outputs", outs, 0);
    rst = 0;
    start = 0;
    w0 = nw;
    repeat (5) @(posedge clk);
    #1 chk("no write after abort", nw - w0, 0);
    chk("idle after abort", {busy, done}, 0);
    init(1);
    run_start();
    wait_done(320 + BRC, "restart done latency");
    @(posedge clk);
    #1 chk("restart writes", nw - bw, 2*NB + BRW);
    for (int j = 0; j < NP; j++) chk($sformatf("restart bin %0d", j), mem[j], ONE);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
